// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a two-digit multiplexed 7-segment bus: debounces each pattern,
// decodes it and holds both digits. Define SEGS_SYNC_EN to add a 2-flop input synchronizer.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] segs,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic        d1_valid,
    output logic        d2_valid,
    output logic        update,
    output logic        frame,
    output logic        code_err,
    output logic        stale
);

    // state      | meaning
    // S_WAIT_SEL | bus blanked, waiting for exactly one digit select
    // S_SETTLE   | counting consecutive identical samples
    // S_ACCEPT   | pattern accepted this cycle (update or code_err pulse)
    // S_HOLD     | accepted pattern still on the bus; wait for any change

    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]      STABLE_C = 4'(STABLE_CYCLES);
    localparam logic [TW-1:0]   TMO_C    = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_WAIT_SEL,
        S_SETTLE,
        S_ACCEPT,
        S_HOLD
    } state_t;

    logic [11:0] segs_in;

`ifdef SEGS_SYNC_EN
    logic [11:0] sync_a;
    logic [11:0] sync_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= segs;
            sync_b <= sync_a;
        end
    end

    assign segs_in = sync_b;
`else
    assign segs_in = segs;
`endif

    logic unused_segs;
    assign unused_segs = ^{segs_in[11:10], segs_in[8]};

    // Packed as {sel2, sel1, g..a}; ignored bus bits never reach the compare logic
    logic [8:0]    samp;
    logic [8:0]    prev;
    logic [8:0]    lock;
    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nxt;
    logic [TW-1:0] idle;
    logic [TW-1:0] idle_inc;
    logic          seen1;
    logic          seen2;
    logic          sel1;
    logic          blank;
    logic          dec_legal;
    logic [3:0]    dec_val;
    logic          enter_acc;
    logic          upd_nxt;

    assign sel1     = samp[7] & ~samp[8];
    assign blank    = ~(samp[7] ^ samp[8]);
    assign idle_inc = idle + TW'(1);

    always_comb begin
        dec_legal = 1'b1;
        dec_val   = 4'd0;
        case (samp[6:0])
            7'h3F: dec_val = 4'd0;
            7'h06: dec_val = 4'd1;
            7'h5B: dec_val = 4'd2;
            7'h4F: dec_val = 4'd3;
            7'h66: dec_val = 4'd4;
            7'h6D: dec_val = 4'd5;
            7'h7D: dec_val = 4'd6;
            7'h07: dec_val = 4'd7;
            7'h7F: dec_val = 4'd8;
            7'h6F: dec_val = 4'd9;
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_WAIT_SEL: begin
                if (!blank) begin
                    cnt_nxt   = 4'd1;
                    state_nxt = (STABLE_C == 4'd1) ? S_ACCEPT : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (samp == prev) begin
                    cnt_nxt = cnt + 4'd1;
                    if (cnt_nxt >= STABLE_C) begin
                        state_nxt = S_ACCEPT;
                    end
                end else if (blank) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = S_WAIT_SEL;
                end else begin
                    cnt_nxt   = 4'd1;
                    state_nxt = (STABLE_C == 4'd1) ? S_ACCEPT : S_SETTLE;
                end
            end
            S_ACCEPT: begin
                cnt_nxt   = 4'd0;
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                // Compared against the accepted pattern so a change during ACCEPT is not lost
                if (samp != lock) begin
                    if (blank) begin
                        cnt_nxt   = 4'd0;
                        state_nxt = S_WAIT_SEL;
                    end else begin
                        cnt_nxt   = 4'd1;
                        state_nxt = (STABLE_C == 4'd1) ? S_ACCEPT : S_SETTLE;
                    end
                end
            end
            default: begin
                cnt_nxt   = 4'd0;
                state_nxt = S_WAIT_SEL;
            end
        endcase
    end

    assign enter_acc = (state_nxt == S_ACCEPT);
    assign upd_nxt   = enter_acc & dec_legal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_WAIT_SEL;
            cnt   <= '0;
            samp  <= '0;
            prev  <= '0;
            lock  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            samp  <= {segs_in[9], segs_in[7], segs_in[6:0]};
            prev  <= samp;
            if (enter_acc) begin
                lock <= samp;
            end
        end
    end

    // Output pulses are registered so they line up with the ACCEPT state cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit1   <= '0;
            digit2   <= '0;
            d1_valid <= 1'b0;
            d2_valid <= 1'b0;
            update   <= 1'b0;
            frame    <= 1'b0;
            code_err <= 1'b0;
            stale    <= 1'b0;
            seen1    <= 1'b0;
            seen2    <= 1'b0;
            idle     <= '0;
        end else begin
            update   <= upd_nxt;
            code_err <= enter_acc & ~dec_legal;
            frame    <= 1'b0;
            if (upd_nxt) begin
                idle  <= '0;
                stale <= 1'b0;
                if (sel1) begin
                    digit1   <= dec_val;
                    d1_valid <= 1'b1;
                    if (seen2) begin
                        frame <= 1'b1;
                        seen1 <= 1'b0;
                        seen2 <= 1'b0;
                    end else begin
                        seen1 <= 1'b1;
                    end
                end else begin
                    digit2   <= dec_val;
                    d2_valid <= 1'b1;
                    if (seen1) begin
                        frame <= 1'b1;
                        seen1 <= 1'b0;
                        seen2 <= 1'b0;
                    end else begin
                        seen2 <= 1'b1;
                    end
                end
            end else if (idle != TMO_C) begin
                idle <= idle_inc;
                if (idle_inc == TMO_C) begin
                    stale    <= 1'b1;
                    d1_valid <= 1'b0;
                    d2_valid <= 1'b0;
                    seen1    <= 1'b0;
                    seen2    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (default build, STABLE_CYCLES=3, TIMEOUT_CYCLES=1000).
module tb_seg_scan_decoder;

    logic        clk;
    logic        reset;
    logic [11:0] segs;
    logic [3:0]  digit1;
    logic [3:0]  digit2;
    logic        d1_valid;
    logic        d2_valid;
    logic        update;
    logic        frame;
    logic        code_err;
    logic        stale;

    int n_cmp = 0;
    int n_err = 0;
    int upd_n, err_n, frm_n, upd_at, err_at, frm_at;

    seg_scan_decoder #(
        .STABLE_CYCLES (3),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .segs    (segs),
        .digit1  (digit1),
        .digit2  (digit2),
        .d1_valid(d1_valid),
        .d2_valid(d2_valid),
        .update  (update),
        .frame   (frame),
        .code_err(code_err),
        .stale   (stale)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a pattern at a falling edge and watch n rising edges, sampling at each falling edge
    task automatic hold(input logic [11:0] p, input int n);
        segs   = p;
        upd_n  = 0;
        err_n  = 0;
        frm_n  = 0;
        upd_at = 0;
        err_at = 0;
        frm_at = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (update === 1'b1) begin
                upd_n++;
                if (upd_at == 0) upd_at = i;
            end
            if (code_err === 1'b1) begin
                err_n++;
                if (err_at == 0) err_at = i;
            end
            if (frame === 1'b1) begin
                frm_n++;
                if (frm_at == 0) frm_at = i;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        segs  = 12'h000;
        @(negedge clk);
        chk("reset_outputs", {digit1, digit2, d1_valid, d2_valid, update, frame, code_err, stale}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // digit1 = 3, first capture after reset
        hold(12'h0CF, 5);
        chk("t1_upd_count", upd_n, 1);
        chk("t1_upd_latency", upd_at, 4);
        chk("t1_frame", frm_n, 0);
        chk("t1_digit1", digit1, 4'd3);
        chk("t1_d1_valid", d1_valid, 1'b1);
        chk("t1_d2_valid", d2_valid, 1'b0);

        // alternating digits: frame only on digit-2 updates
        for (int k = 0; k < 2; k++) begin
            hold(12'h0E6, 4);
            chk("t2_d1_upd_at", upd_at, 4);
            chk("t2_d1_frame", frm_n, 0);
            chk("t2_digit1", digit1, 4'd4);
            hold(12'h27F, 4);
            chk("t2_d2_upd_at", upd_at, 4);
            chk("t2_d2_frame_n", frm_n, 1);
            chk("t2_d2_frame_at", frm_at, 4);
            chk("t2_digit2", digit2, 4'd8);
            chk("t2_d2_valid", d2_valid, 1'b1);
        end

        // too-short pattern followed by a stable one
        hold(12'h0CF, 2);
        chk("t3_short_upd", upd_n, 0);
        hold(12'h086, 4);
        chk("t3_upd_at", upd_at, 4);
        chk("t3_digit1", digit1, 4'd1);

        // illegal glyph "A": one code_err, nothing written, no repeat while held
        hold(12'h0F7, 6);
        chk("t4_err_n", err_n, 1);
        chk("t4_err_at", err_at, 4);
        chk("t4_upd_n", upd_n, 0);
        chk("t4_digit1", digit1, 4'd1);

        // timeout: last update was 6 edges ago, stale rises on the 1000th idle edge
        hold(12'h280, 993);
        chk("t5_stale_before", stale, 1'b0);
        chk("t5_d1_valid_before", d1_valid, 1'b1);
        chk("t5_blank_upd", upd_n, 0);
        hold(12'h280, 1);
        chk("t5_stale_at", stale, 1'b1);
        chk("t5_d1_valid", d1_valid, 1'b0);
        chk("t5_d2_valid", d2_valid, 1'b0);
        chk("t5_digit1_kept", digit1, 4'd1);
        chk("t5_digit2_kept", digit2, 4'd8);
        hold(12'h000, 5);
        chk("t5_stale_sat", stale, 1'b1);

        // recovery on digit 2; seen flags were cleared so no frame
        hold(12'h27D, 3);
        chk("t5_rec_pre_upd", upd_n, 0);
        chk("t5_rec_pre_stale", stale, 1'b1);
        hold(12'h27D, 1);
        chk("t5_rec_update", update, 1'b1);
        chk("t5_rec_stale", stale, 1'b0);
        chk("t5_rec_digit2", digit2, 4'd6);
        chk("t5_rec_frame", frame, 1'b0);
        chk("t5_rec_d1_valid", d1_valid, 1'b0);

        // blanking mid-settle restarts the count; then digit1 completes the frame
        hold(12'h0E6, 2);
        hold(12'h000, 1);
        hold(12'h0E6, 4);
        chk("t7_restart_upd_at", upd_at, 4);
        chk("t7_frame", frm_n, 1);
        chk("t7_digit1", digit1, 4'd4);

        // ignored bus bits toggling is not a change
        hold(12'hDE6, 4);
        chk("t7_ignored_bits", upd_n + err_n, 0);

        // both selects / no select are blanking even with a legal glyph
        hold(12'h2CF, 5);
        chk("t7_both_sel", upd_n + err_n, 0);
        hold(12'h04F, 5);
        chk("t7_no_sel", upd_n + err_n, 0);

        // reset mid-settle
        hold(12'h0ED, 2);
        chk("t6_pre_upd", upd_n, 0);
        reset = 1'b0;
        #1;
        chk("t6_async_clear", {digit1, digit2, d1_valid, d2_valid, update, frame, code_err, stale}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t6_held_clear", {digit1, digit2, d1_valid, d2_valid, update, frame, code_err, stale}, 32'h0);
        reset = 1'b1;
        hold(12'h0ED, 4);
        chk("t6_upd_at", upd_at, 4);
        chk("t6_digit1", digit1, 4'd5);
        chk("t6_digit2", digit2, 4'd0);
        chk("t6_d2_valid", d2_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
